// File: rtl/enemy_draw_arbiter_if.sv
// Signal bundle between the enemy sprite sources, the draw arbiter and the
// vector draw engine. The arbiter takes the slave side.
interface enemy_draw_arbiter_if #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DAC_WIDTH    = 8
);
  logic                    frame_start;
  logic                    spawn_enemy1, spawn_enemy2, spawn_enemy3;
  logic [DAC_WIDTH-1:0]    xenemy1, xenemy2, xenemy3;
  logic [ADDRESSWIDTH-1:0] adr_enemy1, adr_enemy2, adr_enemy3;
  logic                    draw_done;
  logic                    draw_start;
  logic [ADDRESSWIDTH-1:0] draw_adr;
  logic [DAC_WIDTH-1:0]    draw_xoff;
  logic [2:0]              grant;
  logic                    busy, frame_done, overrun, timeout;

  modport slave (
    input  frame_start, spawn_enemy1, spawn_enemy2, spawn_enemy3,
           xenemy1, xenemy2, xenemy3, adr_enemy1, adr_enemy2, adr_enemy3,
           draw_done,
    output draw_start, draw_adr, draw_xoff, grant, busy, frame_done,
           overrun, timeout
  );

  modport master (
    output frame_start, spawn_enemy1, spawn_enemy2, spawn_enemy3,
           xenemy1, xenemy2, xenemy3, adr_enemy1, adr_enemy2, adr_enemy3,
           draw_done,
    input  draw_start, draw_adr, draw_xoff, grant, busy, frame_done,
           overrun, timeout
  );
endinterface

// File: rtl/enemy_draw_arbiter.sv
// Round-robin arbiter sharing one vector draw engine between three enemy
// sprites per frame, with a per-sprite watchdog and sticky error flags.
module enemy_draw_arbiter #(
  parameter int ADDRESSWIDTH   = 16,
  parameter int DAC_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk40MHz,
  input logic                 rst,
  enemy_draw_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              pending_q, pending_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [1:0]              base_q, base_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    draw_start_q, draw_start_d;
  logic [ADDRESSWIDTH-1:0] adr_q, adr_d;
  logic [DAC_WIDTH-1:0]    xoff_q, xoff_d;
  logic [2:0]              grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic                    issue;
  logic [2:0]              sel;

  logic [2:0]                   spawn_v;
  logic [2:0][ADDRESSWIDTH-1:0] adr_arr;
  logic [2:0][DAC_WIDTH-1:0]    x_arr;

  assign spawn_v = {bus.spawn_enemy3, bus.spawn_enemy2, bus.spawn_enemy1};
  assign adr_arr = {bus.adr_enemy3, bus.adr_enemy2, bus.adr_enemy1};
  assign x_arr   = {bus.xenemy3, bus.xenemy2, bus.xenemy1};

  // First set bit of p, scanning 0->1->2 cyclically from base; one-hot result.
  function automatic logic [2:0] pick(input logic [2:0] p, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    logic       found;
    r     = 3'b000;
    found = 1'b0;
    idx   = base;
    for (int k = 0; k < 3; k++) begin
      if (!found && p[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    draw_start_d = 1'b0;
    adr_d        = adr_q;
    xoff_d       = xoff_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (bus.frame_start && state_q != IDLE);
    timeout_d    = timeout_q;
    issue        = 1'b0;
    sel          = 3'b000;

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          pending_d = spawn_v;
          base_d    = rr_ptr_q;
          rr_ptr_d  = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
          if (spawn_v != 3'b000) issue = 1'b1;
          else                   frame_done_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (bus.draw_done || cnt_q == CNT_MAX) begin
          pending_d = pending_q & ~grant_q;
          if (!bus.draw_done) timeout_d = 1'b1;
          if (pending_d != 3'b000) begin
            issue = 1'b1;
          end else begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            grant_d      = 3'b000;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch: outputs are registered, so the selection made on this edge is
    // what the draw engine sees during the ISSUE cycle.
    if (issue) begin
      sel          = pick(pending_d, base_d);
      state_d      = ISSUE;
      draw_start_d = 1'b1;
      grant_d      = sel;
      busy_d       = 1'b1;
      cnt_d        = '0;
      for (int i = 0; i < 3; i++) begin
        if (sel[i]) begin
          adr_d  = adr_arr[i];
          xoff_d = x_arr[i];
        end
      end
    end
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 3'b000;
      rr_ptr_q     <= 2'd0;
      base_q       <= 2'd0;
      cnt_q        <= '0;
      draw_start_q <= 1'b0;
      adr_q        <= '0;
      xoff_q       <= '0;
      grant_q      <= 3'b000;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      draw_start_q <= draw_start_d;
      adr_q        <= adr_d;
      xoff_q       <= xoff_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.draw_start = draw_start_q;
  assign bus.draw_adr   = adr_q;
  assign bus.draw_xoff  = xoff_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_enemy_draw_arbiter.sv
// Directed bench for enemy_draw_arbiter: expected draws are queued when a
// frame is launched and checked as each draw_start appears.
module tb_enemy_draw_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_done = 1'b0;
  logic man_done  = 1'b0;
  bit   resp_en   = 1'b1;
  int   n_tests   = 0;
  int   n_fail    = 0;

  logic [AW-1:0] adr_v [3];
  logic [DW-1:0] x_v   [3];

  typedef struct {
    logic [2:0]    g;
    logic [AW-1:0] a;
    logic [DW-1:0] x;
  } exp_t;
  exp_t exp_q[$];

  logic [2:0]    h_grant;
  logic [AW-1:0] h_adr;
  logic [DW-1:0] h_x;

  enemy_draw_arbiter_if #(.ADDRESSWIDTH(AW), .DAC_WIDTH(DW)) bus();

  enemy_draw_arbiter #(.ADDRESSWIDTH(AW), .DAC_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk40MHz(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #12 clk = ~clk;

  assign bus.adr_enemy1 = adr_v[0];
  assign bus.adr_enemy2 = adr_v[1];
  assign bus.adr_enemy3 = adr_v[2];
  assign bus.xenemy1    = x_v[0];
  assign bus.xenemy2    = x_v[1];
  assign bus.xenemy3    = x_v[2];
  assign bus.draw_done  = resp_done | man_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    exp_t e;
    e.g = 3'b001 << (n - 1);
    e.a = adr_v[n-1];
    e.x = x_v[n-1];
    exp_q.push_back(e);
  endtask

  task automatic set_spawn(input logic [2:0] s);
    bus.spawn_enemy1 = s[0];
    bus.spawn_enemy2 = s[1];
    bus.spawn_enemy3 = s[2];
  endtask

  // Returns at the negedge of the first cycle after frame_start was sampled.
  task automatic start_frame(input logic [2:0] s);
    @(negedge clk);
    set_spawn(s);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, output int ncyc);
    bit got;
    got  = 1'b0;
    ncyc = 0;
    while (!got && ncyc < 400) begin
      @(negedge clk);
      ncyc++;
      if (bus.frame_done) got = 1'b1;
      else chk({tag, " busy"}, bus.busy, 1);
    end
    chk({tag, " frame_done seen"}, got, 1);
    if (got) begin
      chk({tag, " busy at done"}, bus.busy, 0);
      chk({tag, " grant at done"}, bus.grant, 0);
      chk({tag, " draws left"}, exp_q.size(), 0);
    end
  endtask

  // Draw engine model: draw_done five cycles after each draw_start.
  initial forever begin
    @(negedge clk);
    while (resp_en && bus.draw_start) begin
      repeat (4) @(negedge clk);
      resp_done = 1'b1;
      @(negedge clk);
      resp_done = 1'b0;
    end
  end

  // Scoreboard and hold check
  always @(negedge clk) begin
    if (!rst && bus.draw_start) begin
      chk("draw_start expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant", bus.grant, e.g);
        chk("draw_adr", bus.draw_adr, e.a);
        chk("draw_xoff", bus.draw_xoff, e.x);
      end
      h_grant = bus.grant;
      h_adr   = bus.draw_adr;
      h_x     = bus.draw_xoff;
    end else if (!rst && bus.busy) begin
      chk("grant hold", bus.grant, h_grant);
      chk("adr hold", bus.draw_adr, h_adr);
      chk("xoff hold", bus.draw_xoff, h_x);
    end
  end

  initial begin
    int n;
    adr_v = '{16'h0100, 16'h0200, 16'h0300};
    x_v   = '{8'd10, 8'd20, 8'd30};
    bus.frame_start = 1'b0;
    set_spawn(3'b000);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst draw_start", bus.draw_start, 0);
    chk("rst grant", bus.grant, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst frame_done", bus.frame_done, 0);
    chk("rst overrun", bus.overrun, 0);
    chk("rst timeout", bus.timeout, 0);
    rst = 1'b0;

    // Frame 1: order 1,2,3
    push(1); push(2); push(3);
    start_frame(3'b111);
    chk("f1 draw_start next cycle", bus.draw_start, 1);
    chk("f1 busy next cycle", bus.busy, 1);
    wait_fd("f1", n);
    chk("f1 frame_done latency", n, 15);
    chk("f1 timeout", bus.timeout, 0);

    // Frames 2 and 3: rotating start
    push(2); push(3); push(1);
    start_frame(3'b111);
    wait_fd("f2", n);
    push(3); push(1); push(2);
    start_frame(3'b111);
    wait_fd("f3", n);

    // Empty frame still advances the pointer
    start_frame(3'b000);
    chk("empty frame_done", bus.frame_done, 1);
    chk("empty draw_start", bus.draw_start, 0);
    chk("empty busy", bus.busy, 0);
    push(2); push(3); push(1);
    start_frame(3'b111);
    wait_fd("after empty", n);
    start_frame(3'b000);
    chk("empty2 frame_done", bus.frame_done, 1);

    // Spawn 101, enemy2 appears mid-frame
    push(1); push(3);
    start_frame(3'b101);
    bus.spawn_enemy2 = 1'b1;
    wait_fd("spawn101", n);

    // Watchdog: draw engine never answers
    resp_en = 1'b0;
    adr_v = '{16'hBEEF, 16'h1234, 16'h0300};
    x_v   = '{8'd7, 8'd99, 8'd30};
    push(2); push(1);
    start_frame(3'b011);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.draw_start && n < 100);
    chk("timeout abort spacing", n, 17);
    chk("timeout flag", bus.timeout, 1);
    wait_fd("timeout", n);
    chk("timeout frame_done spacing", n, 17);
    chk("timeout sticky", bus.timeout, 1);
    resp_en = 1'b1;

    // Overrun; frame_start in the frame_done cycle is accepted
    push(3); push(1); push(2);
    start_frame(3'b111);
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("overrun set", bus.overrun, 1);
    wait_fd("overrun frame", n);
    set_spawn(3'b000);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("back-to-back accepted", bus.frame_done, 1);
    chk("overrun sticky", bus.overrun, 1);

    // Reset mid-WAIT, then a late draw_done
    resp_en = 1'b0;
    push(2);
    start_frame(3'b111);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst draw_start", bus.draw_start, 0);
    chk("midrst grant", bus.grant, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst overrun", bus.overrun, 0);
    chk("midrst timeout", bus.timeout, 0);
    chk("midrst draw_adr", bus.draw_adr, 0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late done draw_start", bus.draw_start, 0);
      chk("late done frame_done", bus.frame_done, 0);
      chk("late done busy", bus.busy, 0);
    end
    resp_en = 1'b1;
    push(1); push(2); push(3);
    start_frame(3'b111);
    wait_fd("post reset", n);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
